// File: rtl/simon_key_expander_if.sv
// simon_key_expander_if
//   Bundles the request and schedule signals between a key-schedule client and
//   the Simon 32/64 key expander.
//   Signals:
//     start      client -> expander  request an expansion of keytext
//     keytext    client -> expander  64-bit master key, k0 in [15:0] .. k3 in [63:48]
//     busy       expander -> client  expansion or commit in progress
//     done       expander -> client  one-cycle pulse after a schedule is committed
//     key_valid  expander -> client  sticky, a schedule has been committed since reset
//     key_total  expander -> client  committed schedule, round key i at [16*i+15:16*i]
//   Modports: master drives the request side (the client), slave is the expander.
interface simon_key_expander_if;
  logic         start;
  logic [63:0]  keytext;
  logic         busy;
  logic         done;
  logic         key_valid;
  logic [511:0] key_total;

  modport master (
    output start,
    output keytext,
    input  busy,
    input  done,
    input  key_valid,
    input  key_total
  );

  modport slave (
    input  start,
    input  keytext,
    output busy,
    output done,
    output key_valid,
    output key_total
  );
endinterface

// File: rtl/simon_key_expander.sv
// simon_key_expander
//   Iterative Simon 32/64 key schedule. Produces one round key per cycle into a
//   shadow buffer and then copies the whole schedule to key_total in a single
//   cycle, so a downstream cipher pipeline never observes a half-written key.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous reset, active-low; clears the committed schedule
//     bus   simon_key_expander_if.slave (start, keytext, busy, done,
//           key_valid, key_total)
module simon_key_expander #(
  parameter int          ROUNDS = 32,
  parameter logic [61:0] Z_SEQ  = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
  input logic                 clk,
  input logic                 rst,
  simon_key_expander_if.slave bus
);

  // The final generated word goes to slot ROUNDS-1, i.e. when cnt = ROUNDS-5.
  localparam logic [4:0] LAST_CNT = 5'(ROUNDS - 5);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    COMMIT
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [4:0]              cnt;
  logic [ROUNDS-1:0][15:0] shadow;
  logic [ROUNDS*16-1:0]    key_total_q;
  logic                    done_q;
  logic                    key_valid_q;

  logic [15:0]             w3;
  logic [15:0]             tmp;
  logic                    z_bit;
  logic [15:0]             new_word;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. start is only looked at in IDLE, so requests made
  // while busy are dropped rather than queued.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = EXPAND;
      EXPAND:  if (cnt == LAST_CNT) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One step of the Simon 32/64 recurrence, reading only from the shadow
  // buffer. Z_SEQ is stored with z0[0] in the MSB, hence the reversed index.
  always_comb begin
    w3       = shadow[cnt + 5'd3];
    tmp      = {w3[2:0], w3[15:3]} ^ shadow[cnt + 5'd1];
    z_bit    = Z_SEQ[6'd61 - {1'b0, cnt}];
    new_word = ~shadow[cnt] ^ tmp ^ {tmp[0], tmp[15:1]} ^ {15'b0, z_bit} ^ 16'h0003;
  end

  // Datapath: capture the master key, fill the shadow buffer word by word,
  // then publish it. key_total and key_valid only change in COMMIT, so the
  // previous schedule stays usable during a re-expansion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      shadow      <= '0;
      key_total_q <= '0;
      key_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shadow[3:0] <= bus.keytext;
            cnt         <= '0;
          end
        end
        EXPAND: begin
          shadow[cnt + 5'd4] <= new_word;
          cnt                <= cnt + 5'd1;
        end
        COMMIT: begin
          key_total_q <= shadow;
          key_valid_q <= 1'b1;
          done_q      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_total = key_total_q;

endmodule
